// File: rtl/if_switch_pkg.sv
// if_switch_pkg: shared types and constants for the IF-switch serial controller.
//   xfer_state_e     transfer FSM states (IDLE, SHIFT, LATCH, GAP)
//   ENABLE_BIT       bit of the software register word that enables transfers
//   STATUS_*         field offsets/widths of the readback word (used when
//                    IF_SWITCH_READBACK_EN is defined)
package if_switch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    GAP   = 2'd3
  } xfer_state_e;

  localparam int ENABLE_BIT = 31;

  localparam int STATUS_WORD_LSB = 0;
  localparam int STATUS_WORD_W   = 16;
  localparam int STATUS_BUSY_BIT = 16;
  localparam int STATUS_CNT_LSB  = 17;
  localparam int STATUS_CNT_W    = 15;

endpackage

// File: rtl/if_switch_serial_ctrl_if.sv
// if_switch_serial_ctrl_if: groups the register input and serial-link/status
// outputs of if_switch_serial_ctrl.
//   reg_in      software register word (bit 31 enable, low SHIFT_W bits payload)
//   sclk/sdata/le  3-wire serial link to the IF-board latch
//   busy        transfer in progress (including guard gap)
//   sent_word   last payload fully latched
//   status_out  readback word
// Modports: master = controller side, slave = register source / link observer.
interface if_switch_serial_ctrl_if #(
  parameter int SHIFT_W = 16
);
  logic [31:0]        reg_in;
  logic               sclk;
  logic               sdata;
  logic               le;
  logic               busy;
  logic [SHIFT_W-1:0] sent_word;
  logic [31:0]        status_out;

  modport master (
    input  reg_in,
    output sclk, sdata, le, busy, sent_word, status_out
  );

  modport slave (
    output reg_in,
    input  sclk, sdata, le, busy, sent_word, status_out
  );
endinterface

// File: rtl/if_switch_stab_detect.sv
// if_switch_stab_detect: registers a software register word once and reports
// when its payload field has stayed unchanged for STABLE_CYCLES cycles.
//   clk, rst_n  clock, synchronous active-low reset
//   din         raw register word
//   enable      registered din[ENABLE_BIT]
//   stable      payload unchanged for STABLE_CYCLES consecutive cycles
//   payload     registered din[W-1:0]
module if_switch_stab_detect
  import if_switch_pkg::*;
#(
  parameter int W             = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   din,
  output logic          enable,
  output logic          stable,
  output logic [W-1:0]  payload
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [31:0]      q_r;
  logic [CNT_W-1:0] cnt_r;
  logic             unused_q_s;

  // Register the word and count how long its payload has been unchanged;
  // the incoming word is compared with q so the count clears on the same
  // edge at which q takes a new payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r   <= 32'd0;
      cnt_r <= '0;
    end else begin
      q_r <= din;
      if (din[W-1:0] != q_r[W-1:0]) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign enable  = q_r[ENABLE_BIT];
  assign stable  = (cnt_r == CNT_MAX);
  assign payload = q_r[W-1:0];

  // Bits between the payload and the enable are intentionally ignored.
  assign unused_q_s = ^q_r;

endmodule

// File: rtl/if_switch_serial_ctrl.sv
// if_switch_serial_ctrl: qualifies the if_switch software register word and
// shifts each new setting MSB-first over sclk/sdata/le to the IF-board latch.
//   user_clk    sole clock
//   user_rst_n  synchronous active-low reset (abandons any transfer)
//   bus         if_switch_serial_ctrl_if.master: reg_in in; sclk, sdata, le,
//               busy, sent_word, status_out out
// Optional macro IF_SWITCH_READBACK_EN: status_out = {xfer_cnt[14:0], busy,
// sent_word zero-extended to 16}; requires SHIFT_W <= 16. Undefined: status_out = 0.
module if_switch_serial_ctrl
  import if_switch_pkg::*;
#(
  parameter int SHIFT_W       = 16,
  parameter int CLK_DIV       = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int LE_CYCLES     = 2
) (
  input logic                    user_clk,
  input logic                    user_rst_n,
  if_switch_serial_ctrl_if.master bus
);

  localparam int BIT_W = (SHIFT_W > 1)   ? $clog2(SHIFT_W)   : 1;
  localparam int DIV_W = (CLK_DIV > 1)   ? $clog2(CLK_DIV)   : 1;
  localparam int LE_W  = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(SHIFT_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [LE_W-1:0]  LE_LAST   = LE_W'(LE_CYCLES - 1);

  logic               enable_s;
  logic               stable_s;
  logic [SHIFT_W-1:0] payload_s;
  logic               trigger_s;
  logic               shift_done_s;

  xfer_state_e        state_r;
  logic [SHIFT_W-1:0] word_r;
  logic [BIT_W-1:0]   bit_cnt_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [LE_W-1:0]    le_cnt_r;
  logic               sent_valid_r;
  logic               sclk_r;
  logic               sdata_r;
  logic               le_r;
  logic               busy_r;
  logic [SHIFT_W-1:0] sent_word_r;

  if_switch_stab_detect #(
    .W             (SHIFT_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .din     (bus.reg_in),
    .enable  (enable_s),
    .stable  (stable_s),
    .payload (payload_s)
  );

  assign trigger_s = enable_s && stable_s && (!sent_valid_r || (payload_s != sent_word_r));

  // End of the high phase of bit 0: the cycle that enters LATCH.
  assign shift_done_s = (state_r == SHIFT) && sclk_r && (div_cnt_r == DIV_LAST) &&
                        (bit_cnt_r == '0);

  // Transfer FSM with registered link outputs.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_r      <= IDLE;
      word_r       <= '0;
      bit_cnt_r    <= '0;
      div_cnt_r    <= '0;
      le_cnt_r     <= '0;
      sent_valid_r <= 1'b0;
      sclk_r       <= 1'b0;
      sdata_r      <= 1'b0;
      le_r         <= 1'b0;
      busy_r       <= 1'b0;
      sent_word_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          sclk_r <= 1'b0;
          le_r   <= 1'b0;
          if (trigger_s) begin
            word_r    <= payload_s;
            bit_cnt_r <= BIT_FIRST;
            div_cnt_r <= '0;
            sdata_r   <= payload_s[SHIFT_W-1];
            busy_r    <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            sdata_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end else begin
            div_cnt_r <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else if (shift_done_s) begin
              sclk_r       <= 1'b0;
              le_r         <= 1'b1;
              le_cnt_r     <= '0;
              sent_word_r  <= word_r;
              sent_valid_r <= 1'b1;
              state_r      <= LATCH;
            end else begin
              // Falling edge: present the next lower bit while sclk is low.
              sclk_r    <= 1'b0;
              bit_cnt_r <= bit_cnt_r - BIT_W'(1);
              sdata_r   <= word_r[bit_cnt_r - BIT_W'(1)];
            end
          end
        end
        LATCH: begin
          if (le_cnt_r == LE_LAST) begin
            le_r      <= 1'b0;
            sdata_r   <= 1'b0;
            div_cnt_r <= '0;
            state_r   <= GAP;
          end else begin
            le_cnt_r <= le_cnt_r + LE_W'(1);
          end
        end
        GAP: begin
          if (div_cnt_r == DIV_LAST) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          sclk_r  <= 1'b0;
          sdata_r <= 1'b0;
          le_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
      // Dropping enable forgets the last word so re-enabling resends it.
      if (!enable_s) begin
        sent_valid_r <= 1'b0;
      end
    end
  end

  assign bus.sclk      = sclk_r;
  assign bus.sdata     = sdata_r;
  assign bus.le        = le_r;
  assign bus.busy      = busy_r;
  assign bus.sent_word = sent_word_r;

`ifdef IF_SWITCH_READBACK_EN
  logic [STATUS_CNT_W-1:0]  xfer_cnt_r;
  logic [STATUS_WORD_W-1:0] sent16_s;
  logic [31:0]              status_r;

  assign sent16_s = STATUS_WORD_W'(sent_word_r);

  // Completed-transfer counter (wraps) and registered readback word.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      xfer_cnt_r <= '0;
      status_r   <= 32'd0;
    end else begin
      if (shift_done_s) begin
        xfer_cnt_r <= xfer_cnt_r + STATUS_CNT_W'(1);
      end else begin
        xfer_cnt_r <= xfer_cnt_r;
      end
      status_r[STATUS_CNT_LSB +: STATUS_CNT_W]   <= xfer_cnt_r;
      status_r[STATUS_BUSY_BIT]                  <= busy_r;
      status_r[STATUS_WORD_LSB +: STATUS_WORD_W] <= sent16_s;
    end
  end

  assign bus.status_out = status_r;
`else
  assign bus.status_out = 32'd0;
`endif

endmodule

// File: tb/tb_if_switch_serial_ctrl.sv
// Self-checking bench for if_switch_serial_ctrl (default parameters).
// A negedge monitor reconstructs each transfer from the serial link; the
// directed steps and a randomized phase compare it with a word-level model.
module tb_if_switch_serial_ctrl;

  localparam int SHIFT_W       = 16;
  localparam int CLK_DIV       = 4;
  localparam int STABLE_CYCLES = 4;
  localparam int LE_CYCLES     = 2;
  localparam int BUSY_LEN      = SHIFT_W * 2 * CLK_DIV + LE_CYCLES + CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_switch_serial_ctrl_if #(.SHIFT_W(SHIFT_W)) bus ();

  if_switch_serial_ctrl #(
    .SHIFT_W       (SHIFT_W),
    .CLK_DIV       (CLK_DIV),
    .STABLE_CYCLES (STABLE_CYCLES),
    .LE_CYCLES     (LE_CYCLES)
  ) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .bus        (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- link monitor ----------------
  int cyc = 0, rise_cnt = 0, bad_period = 0, glitch_cnt = 0, le_sclk_cnt = 0;
  int busy_rise_cnt = 0, le_rise_cnt = 0, busy_len = 0, last_busy_len = 0;
  int le_len = 0, last_le_len = 0, nbits = 0, last_nbits = 0, last_rise_cyc = 0;
  int status_bad = 0;
  logic [SHIFT_W-1:0] bits = '0;
  logic [SHIFT_W-1:0] obs_q[$];
  logic p_sclk = 1'b0, p_sdata = 1'b0, p_le = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.busy && !p_busy) begin
      nbits = 0;
      busy_len = 0;
      busy_rise_cnt++;
    end
    if (bus.busy) busy_len++;
    if (!bus.busy && p_busy) last_busy_len = busy_len;
    if (bus.sclk && !p_sclk) begin
      if (nbits > 0 && (cyc - last_rise_cyc) != 2 * CLK_DIV) bad_period++;
      bits = {bits[SHIFT_W-2:0], bus.sdata};
      nbits++;
      last_rise_cyc = cyc;
      rise_cnt++;
    end
    if (bus.sclk && p_sclk && bus.sdata !== p_sdata) glitch_cnt++;
    if (bus.le && bus.sclk) le_sclk_cnt++;
    if (bus.le && !p_le) begin
      le_len = 0;
      le_rise_cnt++;
    end
    if (bus.le) le_len++;
    if (!bus.le && p_le) begin
      last_le_len = le_len;
      last_nbits  = nbits;
      obs_q.push_back(bits);
    end
`ifndef IF_SWITCH_READBACK_EN
    if (bus.status_out !== 32'd0) status_bad++;
`endif
    p_sclk  = bus.sclk;
    p_sdata = bus.sdata;
    p_le    = bus.le;
    p_busy  = bus.busy;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag, output int n);
    n = 0;
    while (bus.busy !== lvl && n < budget) begin
      step();
      n++;
    end
    chk(tag, {31'd0, bus.busy}, {31'd0, lvl});
  endtask

  function automatic logic [SHIFT_W-1:0] obs_at(input int idx);
    logic [SHIFT_W-1:0] xw;
    xw = 16'hxxxx;
    if (idx >= 0 && idx < obs_q.size()) return obs_q[idx];
    return xw;
  endfunction

  task automatic chk_status(input string tag, input int xfers, input logic [15:0] w);
    logic [31:0] exp;
    logic [31:0] cnt32;
    step();
    cnt32 = xfers;
`ifdef IF_SWITCH_READBACK_EN
    exp = {cnt32[14:0], 1'b0, w};
`else
    exp = 32'd0;
`endif
    chk(tag, bus.status_out, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, base, rises_before, le_before, nbefore;
    int exp_xfers;
    logic [15:0] exp_sent, m_last, drv_p, p;
    logic m_valid, en;
    logic [15:0] exp_q[$];

    bus.reg_in = 32'd0;
    rst_n = 1'b0;
    repeat (3) step();

    // Reset state.
    chk("rst_sclk", {31'd0, bus.sclk}, 32'd0);
    chk("rst_sdata", {31'd0, bus.sdata}, 32'd0);
    chk("rst_le", {31'd0, bus.le}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_sent_word", bus.sent_word, 32'd0);
    chk("rst_status", bus.status_out, 32'd0);

    // First transfer: register stage + STABLE_CYCLES of stability + trigger cycle.
    rst_n = 1'b1;
    bus.reg_in = 32'h8000_A5C3;
    wait_busy(1'b1, 50, "t1_start", n);
    chk("t1_latency", n, 1 + STABLE_CYCLES + 1);
    chk("t1_first_sdata", {31'd0, bus.sdata}, 32'd1);
    chk("t1_first_sclk", {31'd0, bus.sclk}, 32'd0);
    wait_busy(1'b0, 300, "t1_end", n);
    chk("t1_busy_len", last_busy_len, BUSY_LEN);
    chk("t1_le_len", last_le_len, LE_CYCLES);
    chk("t1_nbits", last_nbits, SHIFT_W);
    chk("t1_nwords", obs_q.size(), 1);
    chk("t1_word", obs_at(0), 16'hA5C3);
    chk("t1_sent_word", bus.sent_word, 16'hA5C3);
    exp_xfers = 1;
    chk_status("t1_status", exp_xfers, 16'hA5C3);

    // Same word held: no resend.
    rises_before = rise_cnt;
    repeat (1000) step();
    chk("t2_no_rises", rise_cnt, rises_before);
    chk("t2_no_busy", busy_rise_cnt, 1);

    // Payload toggling every 2 cycles never qualifies.
    for (int i = 0; i < 25; i++) begin
      bus.reg_in = 32'h8000_1000 + i;
      step();
      step();
    end
    chk("t3_quiet_noise", busy_rise_cnt, 1);
    bus.reg_in = 32'h8000_0001;
    wait_busy(1'b1, 50, "t3_start", n);
    wait_busy(1'b0, 300, "t3_end", n);
    chk("t3_word", obs_at(1), 16'h0001);
    repeat (300) step();
    chk("t3_one_xfer", busy_rise_cnt, 2);
    exp_xfers = 2;
    chk_status("t3_status", exp_xfers, 16'h0001);

    // Payload change mid-transfer: back-to-back with one idle cycle.
    bus.reg_in = 32'h8000_A5C3;
    wait_busy(1'b1, 50, "t4_start", n);
    repeat (40) step();
    bus.reg_in = 32'h8000_1234;
    wait_busy(1'b0, 300, "t4_end_a", n);
    chk("t4_word_a", obs_at(2), 16'hA5C3);
    chk("t4_busy_len", last_busy_len, BUSY_LEN);
    wait_busy(1'b1, 20, "t4_restart", n);
    chk("t4_gap", n, 1);
    wait_busy(1'b0, 300, "t4_end_b", n);
    chk("t4_word_b", obs_at(3), 16'h1234);
    exp_xfers = 4;
    chk_status("t4_status", exp_xfers, 16'h1234);

    // Reset mid-SHIFT abandons the word.
    le_before = le_rise_cnt;
    nbefore = obs_q.size();
    bus.reg_in = 32'h8000_5555;
    wait_busy(1'b1, 50, "t5_start", n);
    repeat (20) step();
    rst_n = 1'b0;
    step();
    chk("t5_sclk", {31'd0, bus.sclk}, 32'd0);
    chk("t5_le", {31'd0, bus.le}, 32'd0);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_sent_word", bus.sent_word, 32'd0);
    chk("t5_status", bus.status_out, 32'd0);
    rst_n = 1'b1;
    bus.reg_in = 32'd0;
    repeat (200) step();
    chk("t5_no_le", le_rise_cnt, le_before);
    chk("t5_no_word", obs_q.size(), nbefore);

    // Randomized: noise bursts then long holds, against a word-level model.
    exp_xfers = 0;
    exp_sent  = 16'h0000;
    m_last    = 16'h0000;
    m_valid   = 1'b0;
    drv_p     = 16'h0000;
    base      = obs_q.size();
    for (int seg = 0; seg < 12; seg++) begin
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        p = 16'($urandom);
        if (p == drv_p) p = p ^ 16'h0001;
        en = ($urandom_range(0, 3) != 0);
        if (!en) m_valid = 1'b0;
        bus.reg_in = {en, 15'($urandom), p};
        drv_p = p;
        step();
        step();
      end
      p = ($urandom_range(0, 2) == 0) ? m_last : 16'($urandom);
      en = ($urandom_range(0, 4) != 0);
      if (!en) begin
        m_valid = 1'b0;
      end else if (!m_valid || p != m_last) begin
        exp_q.push_back(p);
        m_last = p;
        m_valid = 1'b1;
        exp_sent = p;
        exp_xfers++;
      end
      bus.reg_in = {en, 15'($urandom), p};
      drv_p = p;
      repeat (200) step();
      chk("t6_count", obs_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("t6_word", obs_at(base + i), exp_q[i]);
    end
    chk("t6_sent_word", bus.sent_word, exp_sent);
    chk_status("t6_status", exp_xfers, exp_sent);

    // Link-level properties gathered over the whole run.
    chk("sdata_stable_high", glitch_cnt, 0);
    chk("sclk_period", bad_period, 0);
    chk("le_sclk_low", le_sclk_cnt, 0);
    chk("status_zero", status_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
